// File: rtl/immediate_encoder_pkg.sv
// -----------------------------------------------------------------------------
// immediate_encoder_pkg
// Shared definitions for the ARM data-processing immediate encoder:
//   - FSM state encoding
//   - ROT_STEPS : number of candidate rotations (rotate_imm = 0..15)
//   - IMM8_W    : width of the 8-bit immediate field
//   - ROT_W     : width of the rotate_imm field
// -----------------------------------------------------------------------------
package immediate_encoder_pkg;

    localparam int DATA_W    = 32;
    localparam int ROT_STEPS = 16;
    localparam int IMM8_W    = 8;
    localparam int ROT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SEARCH     = 2'd1,
        ST_SEARCH_INV = 2'd2,
        ST_DONE       = 2'd3
    } enc_state_t;

    // True on the final rotation candidate.
    function automatic logic is_last_rot(input logic [ROT_W-1:0] r);
        return (r == ROT_W'(ROT_STEPS - 1));
    endfunction

endpackage

// File: rtl/immediate_encoder_rot_imm_check.sv
// -----------------------------------------------------------------------------
// rot_imm_check
// Combinational test of one rotation candidate: rotates 'value' left by 2*r
// and reports whether the result fits in the low 8 bits.
// Ports:
//   value  in  32  value under test
//   r      in  4   rotation candidate (rotate_imm)
//   match  out 1   1 = (value ROL 2r) has bits [31:8] all zero
//   imm8   out 8   (value ROL 2r)[7:0]
// -----------------------------------------------------------------------------
module rot_imm_check
    import immediate_encoder_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic [ROT_W-1:0]  r,
    output logic              match,
    output logic [IMM8_W-1:0] imm8
);

    // Value followed by its own upper 30 bits: any 32-bit window taken from
    // this vector at an even offset is a left rotation of the value.
    logic [DATA_W+DATA_W-3:0] value_dbl;
    logic [DATA_W-1:0]        rot_table [ROT_STEPS];
    logic [DATA_W-1:0]        rotated;

    assign value_dbl = {value, value[DATA_W-1:2]};

    genvar gi;
    generate
        for (gi = 0; gi < ROT_STEPS; gi++) begin : g_rot
            // Window starting 2*gi bits below the top == value ROL 2*gi.
            assign rot_table[gi] = value_dbl[(DATA_W+DATA_W-3) - 2*gi -: DATA_W];
        end
    endgenerate

    assign rotated = rot_table[r];
    assign match   = (rotated[DATA_W-1:IMM8_W] == '0);
    assign imm8    = rotated[IMM8_W-1:0];

endmodule

// File: rtl/immediate_encoder.sv
// -----------------------------------------------------------------------------
// immediate_encoder
// Searches for the canonical ARM data-processing immediate encoding of a
// 32-bit constant: the smallest rotate_imm r such that
// eight_immed ROR (2*r) equals the constant. One candidate is tested per
// clock. Optionally retries on the bitwise inverse (MVN form).
//
// Build option: define IMM_ENC_INVERT_EN to enable the inverse search
// (SEARCH_INV state) and the 'inverted' output. Undefined: no inverse search,
// 'inverted' is constant 0.
//
// Ports:
//   clk           in  1   rising-edge clock
//   rst           in  1   synchronous reset, active low
//   in_valid      in  1   constant offered on in_value
//   in_value      in  32  constant to encode
//   in_ready      out 1   idle, offer accepted when in_valid & in_ready
//   out_valid     out 1   result fields valid
//   out_ready     in  1   consumer takes the result
//   shift_operand out 12  {rotate_imm, eight_immed}; 0 when not encodable
//   encodable     out 1   1 = encoding found
//   inverted      out 1   1 = encoding is of ~in_value
// -----------------------------------------------------------------------------
module immediate_encoder
    import immediate_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_value,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] shift_operand,
    output logic        encodable,
    output logic        inverted
);

    enc_state_t             state_reg;
    enc_state_t             state_next;
    logic [DATA_W-1:0]      value_reg;
    logic [ROT_W-1:0]       r_reg;
    logic [ROT_W+IMM8_W-1:0] shift_operand_reg;
    logic                   encodable_reg;

    logic [DATA_W-1:0]      check_value;
    logic                   check_match;
    logic [IMM8_W-1:0]      check_imm8;
    logic                   last_rot;

    assign last_rot = is_last_rot(r_reg);

`ifdef IMM_ENC_INVERT_EN
    logic inverted_reg;
    // Single checker shared by both searches.
    assign check_value = (state_reg == ST_SEARCH_INV) ? ~value_reg : value_reg;
    assign inverted    = inverted_reg;
`else
    assign check_value = value_reg;
    assign inverted    = 1'b0;
`endif

    rot_imm_check u_check (
        .value (check_value),
        .r     (r_reg),
        .match (check_match),
        .imm8  (check_imm8)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (check_match) begin
                    state_next = ST_DONE;
                end else if (last_rot) begin
`ifdef IMM_ENC_INVERT_EN
                    state_next = ST_SEARCH_INV;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef IMM_ENC_INVERT_EN
            ST_SEARCH_INV: begin
                if (check_match || last_rot) begin
                    state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        in_ready  = (state_reg == ST_IDLE);
        out_valid = (state_reg == ST_DONE);
    end

    assign shift_operand = shift_operand_reg;
    assign encodable     = encodable_reg;

    // ------------------------------------------------------------- datapath
    // Result registers are cleared on acceptance so that a failed search
    // leaves shift_operand = 0 without extra logic on the failure path.
    always_ff @(posedge clk) begin
        if (!rst) begin
            value_reg         <= '0;
            r_reg             <= '0;
            shift_operand_reg <= '0;
            encodable_reg     <= 1'b0;
`ifdef IMM_ENC_INVERT_EN
            inverted_reg      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        value_reg         <= in_value;
                        r_reg             <= '0;
                        shift_operand_reg <= '0;
                        encodable_reg     <= 1'b0;
`ifdef IMM_ENC_INVERT_EN
                        inverted_reg      <= 1'b0;
`endif
                    end
                end
                ST_SEARCH: begin
                    if (check_match) begin
                        shift_operand_reg <= {r_reg, check_imm8};
                        encodable_reg     <= 1'b1;
`ifdef IMM_ENC_INVERT_EN
                        inverted_reg      <= 1'b0;
`endif
                    end else if (!last_rot) begin
                        r_reg <= r_reg + ROT_W'(1);
                    end else begin
                        // Restart the rotation count for the inverse search.
                        r_reg             <= '0;
                        shift_operand_reg <= '0;
                        encodable_reg     <= 1'b0;
                    end
                end
`ifdef IMM_ENC_INVERT_EN
                ST_SEARCH_INV: begin
                    if (check_match) begin
                        shift_operand_reg <= {r_reg, check_imm8};
                        encodable_reg     <= 1'b1;
                        inverted_reg      <= 1'b1;
                    end else if (!last_rot) begin
                        r_reg <= r_reg + ROT_W'(1);
                    end else begin
                        r_reg             <= '0;
                        shift_operand_reg <= '0;
                        encodable_reg     <= 1'b0;
                        inverted_reg      <= 1'b0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_immediate_encoder.sv
// -----------------------------------------------------------------------------
// tb_immediate_encoder
// Scoreboard bench: the driver pushes the expected result of every accepted
// constant; an independent monitor pops and compares whenever out_valid is
// seen, also checking latency, hold-stability under back-pressure and the
// return to idle after each handshake.
// -----------------------------------------------------------------------------
module tb_immediate_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_value = 32'h0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] shift_operand;
    logic        encodable;
    logic        inverted;

    immediate_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_value      (in_value),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .shift_operand (shift_operand),
        .encodable     (encodable),
        .inverted      (inverted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic [11:0] sop;
        logic        enc;
        logic        inv;
        int          lat;
        int          accept_cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          stall_left = 0;
    bit          seen = 0;
    bit          hs_pending = 0;
    logic [11:0] snap_sop;
    logic        snap_enc;
    logic        snap_inv;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Smallest r such that v rotated left by 2r is below 256.
    function automatic bit find_rot(input logic [31:0] v, output int r_hit, output logic [7:0] imm);
        logic [63:0] d;
        logic [31:0] rot;
        r_hit = 0;
        imm   = 8'h0;
        for (int r = 0; r < 16; r++) begin
            d   = {32'h0, v} << (2 * r);
            rot = d[31:0] | d[63:32];
            if (rot < 32'd256) begin
                r_hit = r;
                imm   = rot[7:0];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic exp_t model(input logic [31:0] v);
        exp_t       e;
        int         r;
        logic [7:0] imm;
        e.value = v; e.sop = 12'h0; e.enc = 1'b0; e.inv = 1'b0;
        e.lat = 16; e.accept_cyc = 0;
        if (find_rot(v, r, imm)) begin
            e.sop = {4'(r), imm}; e.enc = 1'b1; e.lat = r + 1;
        end else begin
`ifdef IMM_ENC_INVERT_EN
            e.lat = 32;
            if (find_rot(~v, r, imm)) begin
                e.sop = {4'(r), imm}; e.enc = 1'b1; e.inv = 1'b1; e.lat = 17 + r;
            end
`endif
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] v, input logic [11:0] sop,
                                input logic enc, input logic inv, input int lat);
        exp_t e;
        e.value = v; e.sop = sop; e.enc = enc; e.inv = inv; e.lat = lat; e.accept_cyc = 0;
        return e;
    endfunction

    // Offer v, wait for acceptance, push expectation (unless aborted later).
    task automatic issue(input logic [31:0] v, input int stall, input exp_t e, input bit push);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
            return;
        end
        in_valid   = 1'b1;
        in_value   = v;
        stall_left = stall;
        @(negedge clk);
        in_valid   = 1'b0;
        in_value   = $urandom;     // must be ignored while busy
        e.accept_cyc = cyc;
        if (push) sb_q.push_back(e);
        $display("[TB] issue value=0x%08h exp sop=0x%03h enc=%0d inv=%0d lat=%0d",
                 v, e.sop, e.enc, e.inv, e.lat);
    endtask

    task automatic send(input logic [31:0] v, input int stall);
        issue(v, stall, model(v), 1'b1);
    endtask

    // ------------------------------------------------------------- monitor
    initial forever begin
        @(negedge clk);
        if (hs_pending) begin
            hs_pending = 0;
            check("out_valid_after_handshake", 32'(out_valid), 32'd0);
            check("in_ready_after_handshake", 32'(in_ready), 32'd1);
        end else if (out_valid) begin
            if (!seen) begin
                if (sb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_out_valid: got out_valid=1, expected no result pending");
                    cur = mk(32'h0, shift_operand, encodable, inverted, 0);
                end else begin
                    cur = sb_q.pop_front();
                    check("latency", 32'(cyc - cur.accept_cyc), 32'(cur.lat));
                    check("shift_operand", 32'(shift_operand), 32'(cur.sop));
                    check("encodable", 32'(encodable), 32'(cur.enc));
                    check("inverted", 32'(inverted), 32'(cur.inv));
                    $display("[TB] result value=0x%08h sop=0x%03h enc=%0d inv=%0d lat=%0d",
                             cur.value, shift_operand, encodable, inverted, cyc - cur.accept_cyc);
                end
                seen     = 1;
                snap_sop = shift_operand;
                snap_enc = encodable;
                snap_inv = inverted;
            end else begin
                check("hold_shift_operand", 32'(shift_operand), 32'(snap_sop));
                check("hold_encodable", 32'(encodable), 32'(snap_enc));
                check("hold_inverted", 32'(inverted), 32'(snap_inv));
            end
            check("in_ready_in_done", 32'(in_ready), 32'd0);
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_ready) begin
                hs_pending = 1;
                seen       = 0;
            end
        end else begin
            out_ready = 1'(($urandom_range(0, 1)));
        end
    end

    // -------------------------------------------------------------- driver
    initial begin
        logic [63:0] d;
        logic [31:0] v;
        int          n;

        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_shift_operand", 32'(shift_operand), 32'd0);
        check("reset_encodable", 32'(encodable), 32'd0);
        check("reset_inverted", 32'(inverted), 32'd0);
        rst = 1'b1;

        // Directed vectors with hand-derived expectations.
        issue(32'h000000FF, 0, mk(32'h000000FF, 12'h0FF, 1'b1, 1'b0, 1), 1'b1);
        issue(32'hFF000000, 0, mk(32'hFF000000, 12'h4FF, 1'b1, 1'b0, 5), 1'b1);
        issue(32'hF000000F, 0, mk(32'hF000000F, 12'h2FF, 1'b1, 1'b0, 3), 1'b1);
        issue(32'h00000000, 0, mk(32'h00000000, 12'h000, 1'b1, 1'b0, 1), 1'b1);
`ifdef IMM_ENC_INVERT_EN
        issue(32'hFFFFFF00, 0, mk(32'hFFFFFF00, 12'h0FF, 1'b1, 1'b1, 17), 1'b1);
        issue(32'h00000101, 0, mk(32'h00000101, 12'h000, 1'b0, 1'b0, 32), 1'b1);
`else
        issue(32'hFFFFFF00, 0, mk(32'hFFFFFF00, 12'h000, 1'b0, 1'b0, 16), 1'b1);
        issue(32'h00000101, 0, mk(32'h00000101, 12'h000, 1'b0, 1'b0, 16), 1'b1);
`endif
        // Back-pressure: result must hold for 10 stalled cycles.
        issue(32'h000000FF, 10, mk(32'h000000FF, 12'h0FF, 1'b1, 1'b0, 1), 1'b1);

        // Reset abort while r = 3 is under test.
        issue(32'h00000101, 0, model(32'h00000101), 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_shift_operand", 32'(shift_operand), 32'd0);
        check("abort_encodable", 32'(encodable), 32'd0);
        $display("[TB] reset abort applied during search");
        rst = 1'b1;
        issue(32'h000000FF, 0, mk(32'h000000FF, 12'h0FF, 1'b1, 1'b0, 1), 1'b1);

        // Randomized constants from several classes.
        for (int i = 0; i < 40; i++) begin
            d = {$urandom_range(0, 255), $urandom_range(0, 255)};
            d = {d[39:32] == 8'h0 ? 32'(d[7:0]) : 32'(d[39:32]),
                 d[39:32] == 8'h0 ? 32'(d[7:0]) : 32'(d[39:32])};
            d = d >> (2 * $urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       v = d[31:0];
                1:       v = ~d[31:0];
                2:       v = $urandom;
                default: v = 32'h00000101 << $urandom_range(0, 23);
            endcase
            send(v, 0);
        end

        n = 0;
        while ((sb_q.size() != 0 || seen || hs_pending) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || seen) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
